// File: rtl/twf_mul_seq_requant.sv
// Sequencer and requantizer for the 16-lane twiddle multiplier of the 512-point FFT:
// drives mul_en/mul_addr, tracks the multiplier register, and rounds <10.13> down to <9.4>.
module twf_mul_seq_requant #(
  parameter int DEPTH      = 16,
  parameter int DIN_WIDTH  = 23,
  parameter int DOUT_WIDTH = 13,
  parameter int SHIFT      = 9,
  parameter int ADDR_WIDTH = 9,
  parameter int NPOINT     = 512
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic                                 in_sof,
  output logic                                 in_ready,
  output logic                                 mul_en,
  output logic [ADDR_WIDTH-1:0]                mul_addr,
  input  logic [DEPTH-1:0][DIN_WIDTH-1:0]      mul_dout_R_add,
  input  logic [DEPTH-1:0][DIN_WIDTH-1:0]      mul_dout_Q_add,
  input  logic [DEPTH-1:0][DIN_WIDTH-1:0]      mul_dout_R_sub,
  input  logic [DEPTH-1:0][DIN_WIDTH-1:0]      mul_dout_Q_sub,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last,
  output logic [DEPTH-1:0][DOUT_WIDTH-1:0]     dout_R_add,
  output logic [DEPTH-1:0][DOUT_WIDTH-1:0]     dout_Q_add,
  output logic [DEPTH-1:0][DOUT_WIDTH-1:0]     dout_R_sub,
  output logic [DEPTH-1:0][DOUT_WIDTH-1:0]     dout_Q_sub,
  output logic                                 sat_sticky,
  input  logic                                 sat_clr
);

  localparam int NBLK  = NPOINT / DEPTH;
  localparam int CNT_W = $clog2(NBLK);
  localparam int ACC_W = DIN_WIDTH + 1;
  localparam int NPATH = 4;

  localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1 << (SHIFT - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DOUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (DOUT_WIDTH - 1)));

  // One guard bit keeps the half-LSB add from overflowing at the positive extreme.
  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [DIN_WIDTH-1:0] x);
    logic signed [ACC_W-1:0] t;
    t = {x[DIN_WIDTH-1], x};
    t = t + HALF;
    return t >>> SHIFT;
  endfunction

  function automatic logic is_sat(input logic signed [ACC_W-1:0] r);
    return (r > SAT_MAX) || (r < SAT_MIN);
  endfunction

  function automatic logic signed [DOUT_WIDTH-1:0] saturate(input logic signed [ACC_W-1:0] r);
    if (r > SAT_MAX) return SAT_MAX[DOUT_WIDTH-1:0];
    if (r < SAT_MIN) return SAT_MIN[DOUT_WIDTH-1:0];
    return r[DOUT_WIDTH-1:0];
  endfunction

  logic                                        advance;
  logic                                        accept;
  logic [CNT_W-1:0]                            blk_cnt;
  logic [CNT_W-1:0]                            blk_idx;
  logic [CNT_W-1:0]                            blk_next;
  logic                                        vld_p1;
  logic                                        last_p1;
  logic [NPATH-1:0][DEPTH-1:0][DIN_WIDTH-1:0]  prod_p1;
  logic [NPATH-1:0][DEPTH-1:0][DOUT_WIDTH-1:0] rq_p1;
  logic [NPATH-1:0][DEPTH-1:0]                 sat_lane_p1;
  logic [NPATH-1:0][DEPTH-1:0][DOUT_WIDTH-1:0] dout_p2;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign mul_en   = advance;
  assign accept   = in_valid && advance;

  // in_sof forces block 0, which also resynchronises a counter that drifted mid-frame.
  assign blk_idx  = in_sof ? '0 : blk_cnt;
  assign blk_next = (blk_idx == CNT_W'(NBLK - 1)) ? '0 : blk_idx + 1'b1;
  assign mul_addr = ADDR_WIDTH'(blk_idx) * ADDR_WIDTH'(DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt <= '0;
    end else if (accept) begin
      blk_cnt <= blk_next;
    end
  end

  // ---- stage 1: aligned with the multiplier's output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (advance) begin
      vld_p1  <= in_valid;
      last_p1 <= accept && (blk_idx == CNT_W'(NBLK - 1));
    end
  end

  assign prod_p1 = {mul_dout_Q_sub, mul_dout_R_sub, mul_dout_Q_add, mul_dout_R_add};

  always_comb begin
    rq_p1       = '0;
    sat_lane_p1 = '0;
    for (int p = 0; p < NPATH; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        rq_p1[p][i]       = saturate(round_shift($signed(prod_p1[p][i])));
        sat_lane_p1[p][i] = is_sat(round_shift($signed(prod_p1[p][i])));
      end
    end
  end

  // ---- stage 2: requantized output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      dout_p2   <= '0;
    end else if (advance) begin
      out_valid <= vld_p1;
      out_last  <= last_p1;
      dout_p2   <= rq_p1;
    end
  end

  // Junk lanes clocked while vld_p1=0 must not mark the status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_sticky <= 1'b0;
    end else if (advance && vld_p1 && (|sat_lane_p1)) begin
      sat_sticky <= 1'b1;
    end else if (sat_clr) begin
      sat_sticky <= 1'b0;
    end
  end

  assign dout_R_add = dout_p2[0];
  assign dout_Q_add = dout_p2[1];
  assign dout_R_sub = dout_p2[2];
  assign dout_Q_sub = dout_p2[3];

endmodule
